// File: rtl/fft_frame_feeder.sv
// fft_frame_feeder: pops PCM samples from the prefetch FIFO and streams them
// to the FFT core as fixed-length complex frames with a last-sample marker.
module fft_frame_feeder #(
  parameter int FRAME_LEN_LOG2 = 10,
  parameter int IN_W           = 16,
  parameter int OUT_W          = 16
) (
  input  logic                 rd_clk,
  input  logic                 rd_rst,
  input  logic                 enable,
  input  logic                 fifo_rd_vld,
  input  logic [IN_W-1:0]      fifo_rd_data,
  output logic                 fifo_rd_en,
  output logic                 fft_tvalid,
  input  logic                 fft_tready,
  output logic [2*OUT_W-1:0]   fft_tdata,
  output logic                 fft_tlast,
  output logic                 busy,
  output logic                 frame_done,
  output logic [15:0]          frame_cnt,
  output logic [15:0]          starve_cnt
);

  typedef enum logic {
    S_IDLE,
    S_RUN
  } state_t;

  localparam logic [FRAME_LEN_LOG2-1:0] LAST_IDX = '1;

  state_t                    state_q, state_d;
  logic                      tvalid_q, tvalid_d;
  logic [2*OUT_W-1:0]        tdata_q, tdata_d;
  logic                      tlast_q, tlast_d;
  logic [FRAME_LEN_LOG2-1:0] idx_q, idx_d;
  logic                      issue_done_q, issue_done_d;
  logic                      frame_done_q, frame_done_d;
  logic [15:0]               frame_cnt_q, frame_cnt_d;
  logic [15:0]               starve_q, starve_d;

  logic             out_free;
  logic             pop;
  logic             accept;
  logic             last_acc;
  logic             starving;
  logic [OUT_W-1:0] re_ext;

  assign re_ext     = OUT_W'($signed(fifo_rd_data));
  assign out_free   = !tvalid_q || fft_tready;
  assign fifo_rd_en = (state_q == S_RUN) && !issue_done_q && out_free;
  assign pop        = fifo_rd_en && fifo_rd_vld;
  assign accept     = tvalid_q && fft_tready;
  assign last_acc   = accept && tlast_q;
  assign starving   = fifo_rd_en && !fifo_rd_vld;

  always_comb begin
    state_d      = state_q;
    tvalid_d     = tvalid_q;
    tdata_d      = tdata_q;
    tlast_d      = tlast_q;
    idx_d        = idx_q;
    issue_done_d = issue_done_q;
    frame_done_d = 1'b0;
    frame_cnt_d  = frame_cnt_q;
    starve_d     = starve_q;

    unique case (state_q)
      S_IDLE: if (enable) state_d = S_RUN;
      S_RUN:  if (last_acc && !enable) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (pop) begin
      tvalid_d = 1'b1;
      tdata_d  = {{OUT_W{1'b0}}, re_ext};
      tlast_d  = (idx_q == LAST_IDX);
      idx_d    = idx_q + 1'b1;
    end else if (accept) begin
      tvalid_d = 1'b0;
    end

    // Hold off the next frame until the tlast word has drained.
    if (pop && idx_q == LAST_IDX) begin
      issue_done_d = 1'b1;
    end else if (last_acc) begin
      issue_done_d = 1'b0;
    end

    if (last_acc) begin
      frame_done_d = 1'b1;
      frame_cnt_d  = frame_cnt_q + 16'd1;
    end

    if (starving && starve_q != 16'hFFFF) begin
      starve_d = starve_q + 16'd1;
    end
  end

  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      state_q      <= S_IDLE;
      tvalid_q     <= 1'b0;
      tdata_q      <= '0;
      tlast_q      <= 1'b0;
      idx_q        <= '0;
      issue_done_q <= 1'b0;
      frame_done_q <= 1'b0;
      frame_cnt_q  <= '0;
      starve_q     <= '0;
    end else begin
      state_q      <= state_d;
      tvalid_q     <= tvalid_d;
      tdata_q      <= tdata_d;
      tlast_q      <= tlast_d;
      idx_q        <= idx_d;
      issue_done_q <= issue_done_d;
      frame_done_q <= frame_done_d;
      frame_cnt_q  <= frame_cnt_d;
      starve_q     <= starve_d;
    end
  end

  assign fft_tvalid = tvalid_q;
  assign fft_tdata  = tdata_q;
  assign fft_tlast  = tlast_q;
  assign busy       = (state_q == S_RUN);
  assign frame_done = frame_done_q;
  assign frame_cnt  = frame_cnt_q;
  assign starve_cnt = starve_q;

endmodule

// File: doc/fft_frame_feeder.md
# fft_frame_feeder

Downstream consumer of the audio sample prefetch FIFO, running in that FIFO's read-clock domain. Pops 16-bit signed PCM samples, sign-extends them into the real part of a complex word with zero imaginary part, and presents them to the FFT core as fixed-length frames over a valid/ready stream with a last-sample marker. Frames are never truncated: a frame in progress always completes, stalling as needed on FIFO starvation or downstream backpressure. The block also reports frame count and starvation statistics.

## Interface
Parameters:
- FRAME_LEN_LOG2, 10: frame length is 2^FRAME_LEN_LOG2 samples; legal range 3..16.
- IN_W, 16: FIFO sample width, signed two's complement.
- OUT_W, 16: real and imaginary field width; must be ≥ IN_W.

Ports:
- rd_clk  in  1  single clock for the whole block; it is the FIFO read clock.
- rd_rst  in  1  asynchronous, active-high reset.
- enable  in  1  level signal; 1 = start and continue frames; 0 = finish the current frame, then idle.
- fifo_rd_vld  in  1  FIFO head valid; prefetch semantics, so fifo_rd_data is valid whenever this is 1.
- fifo_rd_data  in  IN_W  FIFO head sample.
- fifo_rd_en  out  1  pop strobe; the sample is consumed in any cycle where fifo_rd_en=1 and fifo_rd_vld=1.
- fft_tvalid  out  1  output word valid.
- fft_tready  in  1  downstream accept.
- fft_tdata  out  2*OUT_W  imaginary field in bits [2*OUT_W-1:OUT_W], always 0; real field in bits [OUT_W-1:0], the sign-extended sample.
- fft_tlast  out  1  high on the last sample of each frame.
- busy  out  1  high in state RUN.
- frame_done  out  1  one-cycle pulse when the last sample of a frame is accepted.
- frame_cnt  out  16  count of completed frames; wraps modulo 2^16.
- starve_cnt  out  16  count of starvation cycles; saturates at 0xFFFF.

## Operation
- State machine:
  - IDLE → RUN when enable=1.
  - RUN → IDLE on the cycle the last sample of a frame is accepted (fft_tvalid & fft_tready & fft_tlast) and enable=0.
  - RUN → RUN (next frame) on that same cycle if enable=1.
- Output stage: a single register holding {tdata, tlast}. out_free = !fft_tvalid | fft_tready.
- Pop rule: fifo_rd_en = (state==RUN) & !issue_done & out_free.
  - Only pops with fifo_rd_vld=1 count.
  - A pop loads the output register and sets fft_tvalid=1 in the next cycle.
- If fft_tvalid=1, fft_tready=1, and no pop occurs, fft_tvalid goes to 0.
- fft_tdata, fft_tlast and fft_tvalid are held stable while fft_tvalid=1 and fft_tready=0.
- Sample index counter (FRAME_LEN_LOG2 bits):
  - Increments on each pop.
  - tlast = (index == 2^FRAME_LEN_LOG2−1) at pop time.
  - The index wraps to 0 after that pop.
- issue_done is set by the tlast pop and cleared when that sample is accepted. This keeps a new frame from being issued before the FSM decides between RUN and IDLE.
- enable is sampled only at frame boundaries. Deasserting it mid-frame does not shorten the frame.
- Sign extension: real = {{(OUT_W−IN_W){sample[IN_W−1]}}, sample}.
- starve_cnt increments (saturating) on each cycle with state==RUN, !issue_done, out_free and fifo_rd_vld=0.
- frame_cnt increments and frame_done pulses on each tlast acceptance.

## Timing
- Reset values: state IDLE, fifo_rd_en=0, fft_tvalid=0, fft_tdata=0, fft_tlast=0, busy=0, frame_done=0, frame_cnt=0, starve_cnt=0, index=0, issue_done=0.
- Reset mid-frame discards the partial frame. No tlast is issued for it.
- fifo_rd_en is combinational from state, issue_done, fft_tvalid and fft_tready. All other outputs are registered.
- Latency is 1 cycle from pop to fft_tvalid.
- With fifo_rd_vld=1 and fft_tready=1 held, throughput is 1 sample per cycle within a frame.
- At each frame boundary there is a 1-cycle bubble while the tlast word drains (issue_done).
- Entering RUN from IDLE takes 1 cycle after enable rises; the first pop is possible in the cycle busy=1.
- With fifo_rd_vld=0, fifo_rd_en may be asserted but nothing is consumed and the index does not advance.

## Test plan
- Throughput: FRAME_LEN_LOG2=3, FIFO preloaded with 0..15, enable=1, fft_tready=1.
  - Required: two 8-word frames; fft_tlast on samples 7 and 15; frame_cnt=2; starve_cnt=0; one bubble cycle between frames.
- Sign extension: IN_W=16, OUT_W=24, sample 0x8001.
  - Required: fft_tdata = {24'h0, 24'hFF8001}.
- Backpressure: fft_tready toggled 1/0 pseudo-randomly across one frame.
  - Required: every sample delivered once, in order; tdata held stable while stalled; no FIFO pop while out_free=0.
- Starvation: fifo_rd_vld dropped for 5 cycles mid-frame, fft_tready=1.
  - Required: starve_cnt=5; frame completes with correct tlast position.
- Enable drop: enable deasserted after sample 2 of an 8-sample frame.
  - Required: frame finishes at sample 7 with tlast; frame_done pulses; busy falls the next cycle; no further pops.
- Reset mid-frame: rd_rst asserted after 4 samples, then released and enable=1.
  - Required: all outputs read 0 during reset; the next frame's tlast occurs on the 8th post-reset sample.
